// File: rtl/store_merge_buffer.sv
// -----------------------------------------------------------------------------
// store_merge_buffer
//
// Circular FIFO between the store queue and the memory side. Committed stores
// arrive in program order on NUM_IN ports (port 0 oldest). A store to the same
// 32-bit word as the youngest buffered entry is folded into that entry
// (byte-masked overwrite, wmask OR) when it is safe to do so. Otherwise it
// takes a new entry. The oldest entry is presented on OUT_memReq until the
// memory side accepts it.
//
// Ports
//   clk          : clock, all state updates on the rising edge
//   rst          : synchronous active-high reset
//   IN_uop[i]    : committed store i (valid, addr, data, wmask, isMgmt)
//   OUT_stall[i] : port i not accepted this cycle (registered count only)
//   OUT_memReq   : oldest buffered entry, valid when buffer non-empty
//   IN_memReady  : memory side takes OUT_memReq this cycle
//   OUT_empty    : nothing buffered
// -----------------------------------------------------------------------------

package store_merge_buffer_pkg;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  wmask;
    logic        isMgmt;
  } SQ_UOp;

endpackage

module store_merge_buffer
  import store_merge_buffer_pkg::*;
#(
  parameter int unsigned NUM_IN      = 2,
  parameter int unsigned NUM_ENTRIES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  SQ_UOp             IN_uop [NUM_IN],
  output logic [NUM_IN-1:0] OUT_stall,
  output SQ_UOp             OUT_memReq,
  input  logic              IN_memReady,
  output logic              OUT_empty
);

  localparam int unsigned PW = $clog2(NUM_ENTRIES);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  wmask;
    logic        is_mgmt;
    logic        is_mmio;
  } entry_t;

  // A zero byte mask marks a management op just like the explicit flag.
  function automatic logic uop_is_mgmt(input SQ_UOp u);
    return u.isMgmt || (u.wmask == 4'b0000);
  endfunction

  function automatic logic can_merge(input entry_t e, input SQ_UOp u);
    return !e.is_mmio && !e.is_mgmt && (e.wmask != 4'b0000) &&
           !u.addr[31] && !uop_is_mgmt(u) && (e.addr == u.addr[31:2]);
  endfunction

  function automatic entry_t new_entry(input SQ_UOp u);
    entry_t e;
    e.addr    = u.addr[31:2];
    e.data    = u.data;
    e.wmask   = u.wmask;
    e.is_mgmt = u.isMgmt;
    e.is_mmio = u.addr[31];
    return e;
  endfunction

  entry_t          r_entries [NUM_ENTRIES];
  entry_t          w_entries_d [NUM_ENTRIES];
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [CW-1:0]   r_count;
  logic [PW-1:0]   w_tail_d;
  logic [PW-1:0]   w_last;
  logic [CW-1:0]   w_occ;
  logic [CW-1:0]   w_count_d;
  logic            w_deq;

  // Word-aligned storage: the byte offset bits carry no information.
  logic [2*NUM_IN-1:0] w_unused_addr_lo;

  // ---------------------------------------------------------------------------
  // Stall: port i needs room for itself plus every older port in the same
  // cycle, so it stalls once fewer than i+1 slots remain.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_port
    assign OUT_stall[gi] = r_count > CW'(NUM_ENTRIES - 1 - gi);
    assign w_unused_addr_lo[2*gi +: 2] = IN_uop[gi].addr[1:0];
  end

  assign w_deq = (r_count != '0) && IN_memReady;

  // ---------------------------------------------------------------------------
  // Enqueue / merge. Ports are walked oldest first against a running view of
  // the tail so a younger port can fold into what an older port just wrote.
  // w_occ counts the head, so requiring w_occ >= 2 keeps merges off the head
  // entry, which may be leaving this very cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_entries_d = r_entries;
    w_tail_d    = r_tail;
    w_occ       = r_count;
    w_last      = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (IN_uop[i].valid && !OUT_stall[i]) begin
        w_last = w_tail_d - PW'(1);
        if ((w_occ >= CW'(2)) && can_merge(w_entries_d[w_last], IN_uop[i])) begin
          for (int j = 0; j < 4; j++) begin
            if (IN_uop[i].wmask[j]) begin
              w_entries_d[w_last].data[8*j +: 8] = IN_uop[i].data[8*j +: 8];
            end
          end
          w_entries_d[w_last].wmask = w_entries_d[w_last].wmask | IN_uop[i].wmask;
        end else begin
          w_entries_d[w_tail_d] = new_entry(IN_uop[i]);
          w_tail_d              = w_tail_d + PW'(1);
          w_occ                 = w_occ + CW'(1);
        end
      end
    end
    w_count_d = w_occ - CW'(w_deq);
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= w_deq ? r_head + PW'(1) : r_head;
      r_tail  <= w_tail_d;
      r_count <= w_count_d;
    end
  end

  // Payload needs no reset: it is only observed while count says it is live.
  always_ff @(posedge clk) begin
    r_entries <= w_entries_d;
  end

  // ---------------------------------------------------------------------------
  // Memory-side request, purely from registered state
  // ---------------------------------------------------------------------------
  always_comb begin
    OUT_memReq        = '0;
    OUT_memReq.valid  = (r_count != '0);
    OUT_memReq.addr   = {r_entries[r_head].addr, 2'b00};
    OUT_memReq.data   = r_entries[r_head].data;
    OUT_memReq.wmask  = r_entries[r_head].wmask;
    OUT_memReq.isMgmt = r_entries[r_head].is_mgmt;
  end

  assign OUT_empty = (r_count == '0);

  // ---------------------------------------------------------------------------
  // Occupancy sanity
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      a_count_bound : assert (r_count <= CW'(NUM_ENTRIES));
      a_deq_nonempty : assert (!(w_deq && (r_count == '0)));
    end
  end

endmodule

// File: tb/tb_store_merge_buffer.sv
module tb_store_merge_buffer;
  import store_merge_buffer_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  SQ_UOp      in_uop [2];
  logic [1:0] stall;
  SQ_UOp      mem_req;
  logic       mem_ready;
  logic       empty;

  int n_checks = 0;
  int n_fail   = 0;

  store_merge_buffer #(
    .NUM_IN      (2),
    .NUM_ENTRIES (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .IN_uop      (in_uop),
    .OUT_stall   (stall),
    .OUT_memReq  (mem_req),
    .IN_memReady (mem_ready),
    .OUT_empty   (empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int p, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] m, input logic g);
    in_uop[p].valid  = 1'b1;
    in_uop[p].addr   = a;
    in_uop[p].data   = d;
    in_uop[p].wmask  = m;
    in_uop[p].isMgmt = g;
  endtask

  task automatic idle();
    in_uop[0] = '0;
    in_uop[1] = '0;
  endtask

  task automatic check_head(input string tag, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] m);
    check({tag, ".valid"}, mem_req.valid, 1'b1);
    check({tag, ".addr"},  mem_req.addr,  a);
    check({tag, ".data"},  mem_req.data,  d);
    check({tag, ".wmask"}, mem_req.wmask, m);
  endtask

  initial begin
    rst       = 1'b1;
    mem_ready = 1'b0;
    idle();
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst.empty", empty, 1'b1);
    check("rst.valid", mem_req.valid, 1'b0);
    check("rst.stall", stall, 2'b00);
    check("rst.count", dut.r_count, 3'd0);

    // Single store into empty buffer: visible one cycle later
    drive(0, 32'h1000, 32'h0000BEEF, 4'b0011, 1'b0);
    tick();
    idle();
    check_head("s1", 32'h1000, 32'h0000BEEF, 4'b0011);
    check("s1.empty", empty, 1'b0);
    mem_ready = 1'b1;
    tick();
    check("s1.drained", empty, 1'b1);
    mem_ready = 1'b0;

    // Merge into tail behind a distinct head
    drive(0, 32'h2000, 32'h00000001, 4'b0001, 1'b0);
    tick();
    drive(0, 32'h3000, 32'h000000AA, 4'b0001, 1'b0);
    tick();
    drive(0, 32'h3000, 32'h00BB0000, 4'b0100, 1'b0);
    tick();
    idle();
    check("m.count", dut.r_count, 3'd2);
    check_head("m.h0", 32'h2000, 32'h00000001, 4'b0001);
    mem_ready = 1'b1;
    tick();
    check_head("m.h1", 32'h3000, 32'h00BB00AA, 4'b0101);
    tick();
    check("m.drained", empty, 1'b1);
    mem_ready = 1'b0;

    // Two same-word stores into an empty buffer: tail would be head, no merge
    drive(0, 32'h4000, 32'h11111111, 4'b1111, 1'b0);
    drive(1, 32'h4000, 32'h00002200, 4'b0010, 1'b0);
    tick();
    idle();
    check("e.count", dut.r_count, 3'd2);
    check_head("e.h0", 32'h4000, 32'h11111111, 4'b1111);
    mem_ready = 1'b1;
    tick();
    check_head("e.h1", 32'h4000, 32'h00002200, 4'b0010);
    tick();
    check("e.drained", empty, 1'b1);
    mem_ready = 1'b0;

    // Port 1 merges into the entry port 0 allocates in the same cycle
    drive(0, 32'h2000, 32'h12345678, 4'b1111, 1'b0);
    tick();
    drive(0, 32'h4000, 32'h11111111, 4'b1111, 1'b0);
    drive(1, 32'h4000, 32'h00002200, 4'b0010, 1'b0);
    tick();
    idle();
    check("p.count", dut.r_count, 3'd2);
    check_head("p.h0", 32'h2000, 32'h12345678, 4'b1111);
    mem_ready = 1'b1;
    tick();
    check_head("p.h1", 32'h4000, 32'h11112211, 4'b1111);
    tick();
    check("p.drained", empty, 1'b1);
    mem_ready = 1'b0;

    // Fill to full, stall thresholds, stalled uop held then accepted
    drive(0, 32'h100, 32'h100, 4'b1111, 1'b0);
    drive(1, 32'h200, 32'h200, 4'b1111, 1'b0);
    tick();
    idle();
    check("f.stall2", stall, 2'b00);
    drive(0, 32'h300, 32'h300, 4'b1111, 1'b0);
    tick();
    check("f.stall3", stall, 2'b10);
    check("f.count3", dut.r_count, 3'd3);
    drive(0, 32'h400, 32'h400, 4'b1111, 1'b0);
    tick();
    check("f.stall4", stall, 2'b11);
    check("f.count4", dut.r_count, 3'd4);
    drive(0, 32'h500, 32'h500, 4'b1111, 1'b0);
    tick();
    check("f.held.count", dut.r_count, 3'd4);
    check_head("f.held", 32'h100, 32'h100, 4'b1111);
    mem_ready = 1'b1;
    tick();
    check("f.deq.count", dut.r_count, 3'd3);
    check_head("f.deq", 32'h200, 32'h200, 4'b1111);
    tick();
    idle();
    check("f.acc.count", dut.r_count, 3'd3);
    check_head("f.acc", 32'h300, 32'h300, 4'b1111);
    tick();
    check_head("f.d4", 32'h400, 32'h400, 4'b1111);
    tick();
    check_head("f.d5", 32'h500, 32'h500, 4'b1111);
    tick();
    check("f.drained", empty, 1'b1);

    // Streaming: one store per cycle with memory always ready
    for (int k = 0; k < 4; k++) begin
      drive(0, 32'h600 + 32'h100 * k, 32'(k), 4'b1111, 1'b0);
      tick();
      check_head("t.head", 32'h600 + 32'h100 * k, 32'(k), 4'b1111);
      check("t.stall", stall, 2'b00);
    end
    idle();
    tick();
    check("t.drained", empty, 1'b1);
    mem_ready = 1'b0;

    // MMIO stores never merge
    drive(0, 32'h2000, 32'h0, 4'b1111, 1'b0);
    tick();
    drive(0, 32'h80000000, 32'h00000011, 4'b0001, 1'b0);
    tick();
    drive(0, 32'h80000000, 32'h00002200, 4'b0010, 1'b0);
    tick();
    idle();
    check("io.count", dut.r_count, 3'd3);
    mem_ready = 1'b1;
    tick();
    check_head("io.h1", 32'h80000000, 32'h00000011, 4'b0001);
    tick();
    check_head("io.h2", 32'h80000000, 32'h00002200, 4'b0010);
    tick();
    check("io.drained", empty, 1'b1);
    mem_ready = 1'b0;

    // Mgmt uop between two same-word stores blocks merging
    drive(0, 32'h2000, 32'h0, 4'b1111, 1'b0);
    tick();
    drive(0, 32'h5000, 32'h00000033, 4'b0001, 1'b0);
    tick();
    drive(0, 32'h5000, 32'h0, 4'b0000, 1'b1);
    tick();
    drive(0, 32'h5000, 32'h00004400, 4'b0010, 1'b0);
    tick();
    idle();
    check("mg.count", dut.r_count, 3'd4);
    mem_ready = 1'b1;
    tick();
    check_head("mg.h1", 32'h5000, 32'h00000033, 4'b0001);
    tick();
    check("mg.h2.isMgmt", mem_req.isMgmt, 1'b1);
    check("mg.h2.wmask", mem_req.wmask, 4'b0000);
    tick();
    check_head("mg.h3", 32'h5000, 32'h00004400, 4'b0010);
    check("mg.h3.isMgmt", mem_req.isMgmt, 1'b0);
    tick();
    check("mg.drained", empty, 1'b1);
    mem_ready = 1'b0;

    // Reset wins over same-cycle accept and dequeue
    drive(0, 32'h7000, 32'h7, 4'b1111, 1'b0);
    tick();
    drive(0, 32'h7100, 32'h7, 4'b1111, 1'b0);
    tick();
    drive(0, 32'h7200, 32'h7, 4'b1111, 1'b0);
    tick();
    check("r.count3", dut.r_count, 3'd3);
    mem_ready = 1'b1;
    rst       = 1'b1;
    drive(0, 32'h9000, 32'h9, 4'b1111, 1'b0);
    tick();
    rst = 1'b0;
    idle();
    check("r.empty", empty, 1'b1);
    check("r.valid", mem_req.valid, 1'b0);
    check("r.count", dut.r_count, 3'd0);
    check("r.stall", stall, 2'b00);
    tick();
    check("r.stays.empty", empty, 1'b1);
    check("r.stays.count", dut.r_count, 3'd0);
    mem_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
